// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gemm_pkg
// Description : Shared types and defaults for the GEMM tile controller.
// Revision    : 1.0 - initial release
// ============================================================================
package gemm_pkg;

  // Default operand width, PE-array edge and MAC pipeline depth
  localparam int DEF_IN_DATA_WIDTH = 8;
  localparam int DEF_SQ_DIM        = 4;
  localparam int DEF_MAC_LATENCY   = 1;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } gemm_state_e;

endpackage
`default_nettype wire

// File: rtl/gemm_tile_counter.sv
`default_nettype none
// ============================================================================
// Module      : gemm_tile_counter
// Description : Nested m/n/k wrap counter (k innermost, m outermost) with
//               first/last flags for the current coordinate.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_counter #(
  parameter int SizeWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [SizeWidth-1:0] m_size_i,
  input  logic [SizeWidth-1:0] k_size_i,
  input  logic [SizeWidth-1:0] n_size_i,
  output logic [SizeWidth-1:0] m_o,
  output logic [SizeWidth-1:0] n_o,
  output logic [SizeWidth-1:0] k_o,
  output logic                 k_first_o,
  output logic                 k_last_o,
  output logic                 last_o
);

  logic [SizeWidth-1:0] r_m;
  logic [SizeWidth-1:0] r_n;
  logic [SizeWidth-1:0] r_k;
  logic                 w_m_last;
  logic                 w_n_last;
  logic                 w_k_last;

  assign w_m_last = (r_m == (m_size_i - SizeWidth'(1)));
  assign w_n_last = (r_n == (n_size_i - SizeWidth'(1)));
  assign w_k_last = (r_k == (k_size_i - SizeWidth'(1)));

  // Advance k each enabled cycle, carrying into n and then m on wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else if (clr_i) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else if (en_i) begin
      if (w_k_last) begin
        r_k <= '0;
        if (w_n_last) begin
          r_n <= '0;
          r_m <= w_m_last ? '0 : r_m + SizeWidth'(1);
        end else begin
          r_n <= r_n + SizeWidth'(1);
        end
      end else begin
        r_k <= r_k + SizeWidth'(1);
      end
    end
  end

  assign m_o       = r_m;
  assign n_o       = r_n;
  assign k_o       = r_k;
  assign k_first_o = (r_k == '0);
  assign k_last_o  = w_k_last;
  assign last_o    = w_k_last & w_n_last & w_m_last;

endmodule
`default_nettype wire

// File: rtl/gemm_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gemm_tile_ctrl
// Description : Tile-level GEMM sequencer. Streams A/B tile reads in m,n,k
//               order, aligns valid/init controls to the 1-cycle SRAM data
//               and issues one C write per finished output tile.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_ctrl
  import gemm_pkg::*;
#(
  parameter int InDataWidth = DEF_IN_DATA_WIDTH,
  parameter int SqDim       = DEF_SQ_DIM,
  parameter int AddrWidth   = 16,
  parameter int SizeWidth   = 8,
  parameter int MacLatency  = DEF_MAC_LATENCY
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [SizeWidth-1:0] m_tiles_i,
  input  logic [SizeWidth-1:0] k_tiles_i,
  input  logic [SizeWidth-1:0] n_tiles_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 a_rd_en_o,
  output logic                 b_rd_en_o,
  output logic [AddrWidth-1:0] a_addr_o,
  output logic [AddrWidth-1:0] b_addr_o,
  output logic                 a_valid_o,
  output logic                 b_valid_o,
  output logic                 init_save_o,
  output logic                 acc_clr_o,
  output logic                 c_wr_en_o,
  output logic [AddrWidth-1:0] c_addr_o
);

  // Reject configurations the write pipeline cannot represent
  generate
    if (MacLatency < 1 || SqDim < 1 || InDataWidth < 1) begin : g_param_check
      $error("gemm_tile_ctrl: MacLatency, SqDim and InDataWidth must be >= 1");
    end
  endgenerate

  gemm_state_e          r_state;
  logic [SizeWidth-1:0] r_m_size;
  logic [SizeWidth-1:0] r_k_size;
  logic [SizeWidth-1:0] r_n_size;
  logic                 r_rd_en;
  logic                 r_acc_clr;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_zero;
  logic [SizeWidth-1:0] w_m;
  logic [SizeWidth-1:0] w_n;
  logic [SizeWidth-1:0] w_k;
  logic                 w_k_first;
  logic                 w_k_last;
  logic                 w_last;
  logic [AddrWidth-1:0] w_a_addr;
  logic [AddrWidth-1:0] w_b_addr;
  logic [AddrWidth-1:0] w_c_addr;
  logic                 w_final_wr;

  // Read-return stage, aligned with SRAM data
  logic                 r_vld;
  logic                 r_init;
  logic                 r_vld_klast;
  logic                 r_vld_last;
  logic [AddrWidth-1:0] r_vld_caddr;

  // MAC-latency delay line for the C write strobe, its address and a job-end tag
  logic                 r_wr_en   [MacLatency];
  logic                 r_wr_last [MacLatency];
  logic [AddrWidth-1:0] r_wr_addr [MacLatency];

  assign w_accept = (r_state == ST_IDLE) && start_i;
  assign w_zero   = (m_tiles_i == '0) || (k_tiles_i == '0) || (n_tiles_i == '0);

  gemm_tile_counter #(
    .SizeWidth (SizeWidth)
  ) u_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (w_accept),
    .en_i      (r_rd_en),
    .m_size_i  (r_m_size),
    .k_size_i  (r_k_size),
    .n_size_i  (r_n_size),
    .m_o       (w_m),
    .n_o       (w_n),
    .k_o       (w_k),
    .k_first_o (w_k_first),
    .k_last_o  (w_k_last),
    .last_o    (w_last)
  );

  // Unsigned tile-index arithmetic, wrapping at AddrWidth
  assign w_a_addr = AddrWidth'(w_m) * AddrWidth'(r_k_size) + AddrWidth'(w_k);
  assign w_b_addr = AddrWidth'(w_k) * AddrWidth'(r_n_size) + AddrWidth'(w_n);
  assign w_c_addr = AddrWidth'(w_m) * AddrWidth'(r_n_size) + AddrWidth'(w_n);

  assign w_final_wr = r_wr_en[MacLatency-1] & r_wr_last[MacLatency-1];

  // Sequencer: job acceptance, read phase, drain of in-flight writes, done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_m_size  <= '0;
      r_k_size  <= '0;
      r_n_size  <= '0;
      r_rd_en   <= 1'b0;
      r_acc_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_acc_clr <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_m_size  <= m_tiles_i;
            r_k_size  <= k_tiles_i;
            r_n_size  <= n_tiles_i;
            r_acc_clr <= 1'b1;
            r_busy    <= 1'b1;
            if (w_zero) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_rd_en <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_DRAIN;
            r_rd_en <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_final_wr) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Align per-beat controls with read data, then delay the tile write by MacLatency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld       <= 1'b0;
      r_init      <= 1'b0;
      r_vld_klast <= 1'b0;
      r_vld_last  <= 1'b0;
      r_vld_caddr <= '0;
      for (int i = 0; i < MacLatency; i++) begin
        r_wr_en[i]   <= 1'b0;
        r_wr_last[i] <= 1'b0;
        r_wr_addr[i] <= '0;
      end
    end else begin
      r_vld       <= r_rd_en;
      r_init      <= r_rd_en & w_k_first;
      r_vld_klast <= r_rd_en & w_k_last;
      r_vld_last  <= r_rd_en & w_last;
      r_vld_caddr <= (r_rd_en & w_k_last) ? w_c_addr : '0;
      r_wr_en[0]   <= r_vld_klast;
      r_wr_last[0] <= r_vld_last;
      r_wr_addr[0] <= r_vld_klast ? r_vld_caddr : '0;
      for (int i = 1; i < MacLatency; i++) begin
        r_wr_en[i]   <= r_wr_en[i-1];
        r_wr_last[i] <= r_wr_last[i-1];
        r_wr_addr[i] <= r_wr_addr[i-1];
      end
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign acc_clr_o   = r_acc_clr;
  assign a_rd_en_o   = r_rd_en;
  assign b_rd_en_o   = r_rd_en;
  assign a_addr_o    = r_rd_en ? w_a_addr : '0;
  assign b_addr_o    = r_rd_en ? w_b_addr : '0;
  assign a_valid_o   = r_vld;
  assign b_valid_o   = r_vld;
  assign init_save_o = r_init;
  assign c_wr_en_o   = r_wr_en[MacLatency-1];
  assign c_addr_o    = r_wr_addr[MacLatency-1];

endmodule
`default_nettype wire

// File: doc/gemm_tile_ctrl.md
GEMM_TILE_CTRL -- requirements
Module: gemm_tile_ctrl

Interface
REQ-001 SHALL have parameter InDataWidth, default 8, operand element width (passed through for package consistency).
REQ-002 SHALL have parameter SqDim, default 4, tile edge; the downstream PE array is SqDim x SqDim.
REQ-003 SHALL have parameter AddrWidth, default 16, tile-index address width for the A, B and C memories.
REQ-004 SHALL have parameter SizeWidth, default 8, width of the matrix-size inputs (in tiles).
REQ-005 SHALL have parameter MacLatency, default 1, cycles from the last valid beat into the PE array until c_out is final.
REQ-006 Ports: clk_i in 1, the single clock; rst_ni in 1, asynchronous active-low reset.
REQ-007 Ports: start_i in 1; m_tiles_i, k_tiles_i, n_tiles_i in SizeWidth each; sampled on start accept.
REQ-008 Ports: busy_o out 1; done_o out 1, one-cycle pulse.
REQ-009 Ports: a_rd_en_o, b_rd_en_o out 1; a_addr_o, b_addr_o out AddrWidth (one full tile per read, 1-cycle read latency).
REQ-010 Ports: a_valid_o, b_valid_o, init_save_o, acc_clr_o out 1, driving the PE-array controls.
REQ-011 Ports: c_wr_en_o out 1; c_addr_o out AddrWidth, the write strobe for the PE-array result tile.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DRAIN, FINISH.
REQ-013 IDLE: start_i=1 SHALL latch the sizes, clear the m/n/k counters, pulse acc_clr_o for one cycle and enter RUN; start_i SHALL be ignored in every other state.
REQ-014 If any latched size is 0, the block SHALL go IDLE->FINISH, issue no reads and no writes, then pulse done_o.
REQ-015 RUN: each cycle SHALL assert a_rd_en_o and b_rd_en_o with a_addr_o=m*K+k and b_addr_o=k*N+n, then advance k.
REQ-016 k SHALL wrap at K-1 to 0, advancing n; n SHALL wrap at N-1 to 0, advancing m. The last read is m=M-1, n=N-1, k=K-1, after which the FSM SHALL enter DRAIN.
REQ-017 a_valid_o and b_valid_o SHALL be asserted exactly one cycle after each read, aligned with the returned SRAM data.
REQ-018 init_save_o SHALL be high in the same cycle as the valid beat for k=0, and low for all other beats.
REQ-019 c_wr_en_o SHALL pulse MacLatency cycles after the valid beat for k=K-1, with c_addr_o=m*N+n of that tile.
REQ-020 Result writes SHALL pipeline behind reads without stalls; after the last read, DRAIN SHALL wait until the final c_wr_en_o.
REQ-021 FINISH SHALL pulse done_o for one cycle and return to IDLE.
REQ-022 busy_o SHALL be 1 from the cycle after start accept through the FINISH cycle inclusive.
REQ-023 Address arithmetic SHALL be unsigned, truncated to AddrWidth; overflow is the caller's responsibility.
REQ-024 When K=1, every beat SHALL carry both init_save_o=1 and a following c_wr_en_o.

Reset
REQ-025 rst_ni low SHALL asynchronously force IDLE, zero all counters and pipeline registers, and drive every output to 0, including mid-operation; no write SHALL be issued after reset.

Structure
REQ-026 The state enum, the SqDim/InDataWidth defaults and the MacLatency default SHALL live in the shared gemm package.
REQ-027 One sub-module, gemm_tile_counter (a nested wrap counter for m/n/k with a last flag), SHALL be used; the valid/init/write alignment SHALL be a shift register inside this block.

Verification
REQ-028 M=K=N=1, start -> cycle 1: one read at address 0; next cycle: valid=1 with init_save=1; MacLatency later: c_wr_en=1 at c_addr=0; done pulses once.
REQ-029 M=2, K=3, N=2 -> 12 reads in consecutive cycles; A addresses 0,1,2,0,1,2,3,4,5,3,4,5; B addresses 0,2,4,1,3,5,0,2,4,1,3,5; C writes at 0,1,2,3.
REQ-030 K=0 with M=N=2 -> no rd_en and no c_wr_en; done_o pulses within 2 cycles; busy_o returns to 0.
REQ-031 start_i held high during a run -> the run completes unchanged and no second acc_clr_o pulse occurs until IDLE.
REQ-032 rst_ni asserted at the 5th read of the M=2/K=3/N=2 job -> all outputs are 0 in the same cycle; no c_wr_en_o follows; a new start then runs cleanly.
REQ-033 MacLatency=3, K=1, M=1, N=4 -> four back-to-back writes at c_addr 0..3, each 3 cycles after its valid beat.
